gshare_pred: RTL
================

# gshare_pred

Parametrised gshare direction predictor for the fetch stage, successor to the fixed-size 2-bit predictor. Hashes the fetch PC with a global history register to index a pattern history table (PHT) of N-bit saturating counters. The history is updated speculatively at prediction time, and the resolving branch unit restores it on a mispredict. It supplies a combinational taken/not-taken prediction plus the index and history snapshot that travel with the branch down the pipeline.

## Interface
- XLEN, 32, PC width (from mmm_pkg).
- OFFSET, 2, PC bits dropped below the hash (instruction alignment).
- HLEN, 8, history length and PHT index width; PHT has 2**HLEN entries.
- CNT_W, 2, saturating counter width (1..4).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  synchronous clear of history and PHT.
- pc_i  in  XLEN  fetch PC to predict.
- pred_valid_i  in  1  fetch consumes the prediction this cycle.
- taken_o  out  1  predicted direction for pc_i.
- pred_index_o  out  HLEN  PHT index used (travels with the branch).
- pred_hist_o  out  HLEN  history used for this prediction (checkpoint).
- res_valid_i  in  1  branch resolution valid.
- res_index_i  in  HLEN  PHT index carried from prediction.
- res_hist_i  in  HLEN  history checkpoint carried from prediction.
- res_taken_i  in  1  actual direction.
- res_mispred_i  in  1  resolved direction differed from prediction.

## Operation
- Index: pred_index_o = history_q ^ pc_i[HLEN+OFFSET-1:OFFSET]. pred_hist_o = history_q.
- PHT entry: {valid, count[CNT_W-1:0]}. taken_o = valid & count[CNT_W-1]. An invalid entry predicts not-taken.
- Reset/flush value: history_q = 0. Every entry is valid = 0, count = 2**(CNT_W-1)-1 (weakly not-taken).
- PHT update on res_valid_i at res_index_i:
  - Set valid = 1.
  - res_taken_i = 1: count + 1, saturating at 2**CNT_W-1.
  - res_taken_i = 0: count - 1, saturating at 0.
  - Arithmetic is unsigned CNT_W-bit and never wraps.
- History shift rule: new bit enters at the MSB. next = {bit, hist[HLEN-1:1]}.
- Speculative history update: on pred_valid_i, history_q <= {taken_o, history_q[HLEN-1:1]}.
- Recovery: on res_valid_i & res_mispred_i, history_q <= {res_taken_i, res_hist_i[HLEN-1:1]}.
- Priority on history_q, highest first: rst_i, flush_i, mispredict recovery, pred_valid_i, hold.
- A correctly predicted resolution (res_mispred_i = 0) updates the PHT only; history_q is untouched.
- flush_i during a resolution discards the update. Reset mid-operation discards all state.

## Timing
- Prediction is combinational from pc_i and registered state, with zero-cycle latency. No PHT read port is registered.
- PHT and history updates become visible the cycle after the event.
- Same-cycle read/write of one entry: the prediction sees the old counter, with no bypass.
- One resolution per cycle and one prediction per cycle. There is no backpressure, so no ready signals exist.
- After reset deassertion: taken_o = 0 for any pc_i, pred_hist_o = 0, pred_index_o = pc hash bits.

## Configuration
- GSHARE_SPEC_HIST_EN defined: speculative history and mispredict recovery as above.
- GSHARE_SPEC_HIST_EN undefined:
  - history_q updates only on res_valid_i: {res_taken_i, history_q[HLEN-1:1]}.
  - pred_valid_i, res_hist_i and res_mispred_i are ignored.
  - pred_hist_o still outputs history_q.
  - PHT behaviour is identical in both builds.

## Test plan
All scenarios use HLEN=4, CNT_W=2, OFFSET=2, macro defined unless noted.
- Reset: hold rst_i 1 cycle, then pc_i=0x3C → taken_o=0, pred_index_o=0xF, pred_hist_o=0x0.
- Training and saturation:
  - Two resolutions at index 5, taken=1, mispred=0 → count 01→10→11. pc_i=0x14 gives taken_o=1.
  - A third taken resolution leaves count at 11.
  - Three not-taken resolutions take it to 00, and a fourth leaves it at 00 (taken_o=0).
- Speculative history: history 0x0, index 0 trained to taken, pc_i=0x0, pred_valid_i=1 → pred_hist_o=0x0 that cycle. Next cycle history_q=0x8 and pred_index_o=0x8.
- Mispredict recovery:
  - Two speculative taken predictions give history 0xC.
  - Then res_valid_i=1, res_mispred_i=1, res_hist_i=0x0, res_taken_i=1 → history_q=0x8 next cycle.
  - The same event asserted together with pred_valid_i also gives 0x8, because recovery wins.
- Flush mid-operation: after training index 5 to 11, assert flush_i together with res_valid_i → next cycle all entries invalid, taken_o=0, history_q=0. The concurrent update is lost.
- Macro undefined: pred_valid_i pulses leave history_q unchanged. A resolution with taken=1 and history 0x0 gives 0x8, regardless of res_hist_i and res_mispred_i.

Source files
------------

// File: rtl/gshare_pred.sv
// Gshare direction predictor: PC/history XOR indexes a PHT of valid-tagged saturating counters.
// Build option GSHARE_SPEC_HIST_EN enables speculative history with mispredict recovery.
module gshare_pred #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned OFFSET = 2,
    parameter int unsigned HLEN   = 8,
    parameter int unsigned CNT_W  = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            pred_valid_i,
    output logic            taken_o,
    output logic [HLEN-1:0] pred_index_o,
    output logic [HLEN-1:0] pred_hist_o,
    input  logic            res_valid_i,
    input  logic [HLEN-1:0] res_index_i,
    input  logic [HLEN-1:0] res_hist_i,
    input  logic            res_taken_i,
    input  logic            res_mispred_i
);

    localparam int unsigned Entries = 2 ** HLEN;
    localparam logic [CNT_W-1:0] CntInit = CNT_W'((2 ** (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

    logic [HLEN-1:0]  hist_q, hist_d;
    logic [Entries-1:0] vld_q;
    logic [CNT_W-1:0] cnt_q [Entries];
    logic [CNT_W-1:0] cnt_upd;

    // Only the hashed slice of the PC is used.
    logic unused_pc;
    assign unused_pc = ^pc_i;

    assign pred_index_o = hist_q ^ pc_i[HLEN+OFFSET-1:OFFSET];
    assign pred_hist_o  = hist_q;
    assign taken_o      = vld_q[pred_index_o] & cnt_q[pred_index_o][CNT_W-1];

    always_comb begin
        cnt_upd = cnt_q[res_index_i];
        if (res_taken_i && cnt_upd != CntMax) begin
            cnt_upd = cnt_upd + 1'b1;
        end else if (!res_taken_i && cnt_upd != '0) begin
            cnt_upd = cnt_upd - 1'b1;
        end
    end

`ifdef GSHARE_SPEC_HIST_EN
    // Recovery restores the checkpoint and overrides any same-cycle speculative shift.
    always_comb begin
        hist_d = hist_q;
        if (res_valid_i && res_mispred_i) begin
            hist_d = {res_taken_i, res_hist_i[HLEN-1:1]};
        end else if (pred_valid_i) begin
            hist_d = {taken_o, hist_q[HLEN-1:1]};
        end
    end
`else
    logic unused_spec;
    assign unused_spec = pred_valid_i ^ res_mispred_i ^ (^res_hist_i);

    always_comb begin
        hist_d = hist_q;
        if (res_valid_i) begin
            hist_d = {res_taken_i, hist_q[HLEN-1:1]};
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            hist_q <= '0;
            vld_q  <= '0;
            for (int i = 0; i < Entries; i++) begin
                cnt_q[i] <= CntInit;
            end
        end else begin
            hist_q <= hist_d;
            if (res_valid_i) begin
                vld_q[res_index_i] <= 1'b1;
                cnt_q[res_index_i] <= cnt_upd;
            end
        end
    end

endmodule
